// File: rtl/lfsr11_pkg.sv
// lfsr11_pkg: shared LFSR next-state function, default geometry and checker state type
package lfsr11_pkg;
  localparam int LFSR_WIDTH = 11;
  localparam int LFSR_TAP_A = 11;
  localparam int LFSR_TAP_B = 9;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  function automatic logic [1:LFSR_WIDTH] lfsr_next(input logic [1:LFSR_WIDTH] s, input int ta = LFSR_TAP_A, input int tb = LFSR_TAP_B);
    return {s[ta] ^ s[tb], s[1:LFSR_WIDTH-1]};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear up counter that holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/lfsr11_seq_checker.sv
// lfsr11_seq_checker: locks a local LFSR predictor to received state words and counts word errors
module lfsr11_seq_checker
  import lfsr11_pkg::*;
#(
  parameter int WIDTH      = LFSR_WIDTH,
  parameter int TAP_A      = LFSR_TAP_A,
  parameter int TAP_B      = LFSR_TAP_B,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:WIDTH]   in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             lock_lost
);
  localparam logic [7:0] LC = 8'(LOCK_COUNT);
  localparam logic [7:0] LS = 8'(LOSS_COUNT);
  state_t state;
  logic [1:WIDTH] pred;
  logic [7:0] match_run, miss_run;
  logic match, zero, err_inc;
  assign match = in_data == pred;
  assign zero = in_data == '0;
  assign err_inc = in_valid && state == LOCKED && !match;
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk),
    .clr(reset),
    .inc(err_inc),
    .cnt(err_count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= HUNT;
      pred <= '0;
      match_run <= '0;
      miss_run <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      if (in_valid)
        case (state)
          HUNT:
            if (!zero) begin
              pred <= lfsr_next(in_data, TAP_A, TAP_B);
              match_run <= 8'd1;
              miss_run <= '0;
              state <= LC == 8'd1 ? LOCKED : VERIFY;
              locked <= LC == 8'd1;
            end
          VERIFY:
            if (match) begin
              pred <= lfsr_next(pred, TAP_A, TAP_B);
              match_run <= match_run + 8'd1;
              if (match_run + 8'd1 == LC) begin
                state <= LOCKED;
                locked <= 1'b1;
                miss_run <= '0;
              end
            end else if (zero) state <= HUNT;
            else begin
              pred <= lfsr_next(in_data, TAP_A, TAP_B);
              match_run <= 8'd1;
            end
          LOCKED: begin
            // flywheel: the received word never reseeds a locked predictor
            pred <= lfsr_next(pred, TAP_A, TAP_B);
            if (match) miss_run <= '0;
            else begin
              err_pulse <= 1'b1;
              if (miss_run + 8'd1 == LS) begin
                state <= HUNT;
                locked <= 1'b0;
                lock_lost <= 1'b1;
                miss_run <= '0;
              end else miss_run <= miss_run + 8'd1;
            end
          end
          default: state <= HUNT;
        endcase
    end
endmodule

// File: tb/tb_lfsr11_seq_checker.sv
// tb_lfsr11_seq_checker: randomized stream checks against an index-based reference of the checker
module tb_lfsr11_seq_checker;
  localparam int LOCK = 8;
  localparam int LOSS = 4;
  localparam int PERIOD = 2047;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [1:11] in_data = '0;
  logic locked, err_pulse, lock_lost;
  logic [15:0] err_count;
  int seq[PERIOD];
  int pos[2048];
  int n_checks = 0, n_fail = 0;
  int m_state, m_pidx, m_run, m_miss, m_cnt;
  logic m_locked, m_ep, m_ll;
  int g;

  lfsr11_seq_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // reference: the prediction is a position in the precomputed generator sequence
  task automatic model(input logic r, input logic v, input int d);
    m_ep = 0;
    m_ll = 0;
    if (r) begin
      m_state = 0; m_pidx = 0; m_run = 0; m_miss = 0; m_cnt = 0;
    end else if (v) begin
      if (m_state == 0) begin
        if (d != 0) begin
          m_pidx = (pos[d] + 1) % PERIOD; m_run = 1; m_miss = 0;
          m_state = LOCK == 1 ? 2 : 1;
        end
      end else if (m_state == 1) begin
        if (d == seq[m_pidx]) begin
          m_pidx = (m_pidx + 1) % PERIOD; m_run++;
          if (m_run == LOCK) begin m_state = 2; m_miss = 0; end
        end else if (d == 0) m_state = 0;
        else begin m_pidx = (pos[d] + 1) % PERIOD; m_run = 1; end
      end else begin
        logic hit;
        hit = d == seq[m_pidx];
        m_pidx = (m_pidx + 1) % PERIOD;
        if (hit) m_miss = 0;
        else begin
          m_ep = 1;
          if (m_cnt < 65535) m_cnt++;
          m_miss++;
          if (m_miss == LOSS) begin m_state = 0; m_ll = 1; m_miss = 0; end
        end
      end
    end
    m_locked = m_state == 2;
  endtask

  task automatic step(input logic r, input logic v, input int d);
    reset = r;
    in_valid = v;
    in_data = d[10:0];
    @(posedge clk);
    model(r, v, d);
    #1;
  endtask

  task automatic next_word(output int d);
    d = seq[g % PERIOD];
    g++;
  endtask

  task automatic test_reset;
    step(1, 0, 0);
    step(1, 1, 5);
    n_checks++;
    if ({locked, err_pulse, lock_lost, err_count} !== 19'd0) begin
      n_fail++; $display("FAIL reset_state: got %b %b %b %0d, want all zero", locked, err_pulse, lock_lost, err_count);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, $urandom_range(1, 2047));
      n_checks++;
      if ({locked, err_pulse, lock_lost, err_count} !== {m_locked, m_ep, m_ll, 16'(m_cnt)}) begin
        n_fail++; $display("FAIL reset_idle: got %b%b%b %0d want %b%b%b %0d", locked, err_pulse, lock_lost, err_count, m_locked, m_ep, m_ll, m_cnt);
      end
    end
  endtask

  task automatic test_lock_wrap;
    int d;
    g = 0;
    for (int k = 1; k <= PERIOD + 12; k++) begin
      next_word(d);
      step(0, 1, d);
      n_checks++;
      if (locked !== (k >= LOCK) || err_count !== 16'd0 || err_pulse !== 1'b0) begin
        n_fail++; $display("FAIL lock_wrap word %0d: got locked=%b err=%0d pulse=%b want locked=%b err=0", k, locked, err_count, err_pulse, k >= LOCK);
      end
    end
  endtask

  task automatic test_single_err;
    int d;
    repeat ($urandom_range(3, 20)) begin next_word(d); step(0, 1, d); end
    next_word(d);
    step(0, 1, d ^ 32);
    n_checks++;
    if ({locked, err_pulse, err_count} !== {1'b1, 1'b1, 16'(m_cnt)} || m_cnt != 1) begin
      n_fail++; $display("FAIL single_err: got locked=%b pulse=%b cnt=%0d want 1 1 1", locked, err_pulse, err_count);
    end
    next_word(d);
    step(0, 1, d);
    n_checks++;
    if ({locked, err_pulse, err_count} !== {1'b1, 1'b0, 16'd1}) begin
      n_fail++; $display("FAIL flywheel: got locked=%b pulse=%b cnt=%0d want 1 0 1", locked, err_pulse, err_count);
    end
  endtask

  task automatic test_loss;
    int d;
    step(1, 0, 0);
    for (int k = 0; k < LOCK + 5; k++) begin next_word(d); step(0, 1, d); end
    for (int k = 1; k <= LOSS; k++) begin
      next_word(d);
      step(0, 1, d ^ $urandom_range(1, 2047));
      n_checks++;
      if ({locked, err_pulse, lock_lost, err_count} !== {m_locked, m_ep, m_ll, 16'(m_cnt)}) begin
        n_fail++; $display("FAIL loss_run %0d: got %b%b%b %0d want %b%b%b %0d", k, locked, err_pulse, lock_lost, err_count, m_locked, m_ep, m_ll, m_cnt);
      end
    end
    n_checks++;
    if ({locked, lock_lost, err_count} !== {1'b0, 1'b1, 16'd4}) begin
      n_fail++; $display("FAIL lock_lost: got locked=%b lost=%b cnt=%0d want 0 1 4", locked, lock_lost, err_count);
    end
    for (int k = 1; k <= LOCK; k++) begin
      next_word(d);
      step(0, 1, d);
      n_checks++;
      if (locked !== (k == LOCK) || lock_lost !== 1'b0 || err_count !== 16'd4) begin
        n_fail++; $display("FAIL relock %0d: got locked=%b lost=%b cnt=%0d want locked=%b cnt=4", k, locked, lock_lost, err_count, k == LOCK);
      end
    end
  endtask

  task automatic test_zero_hunt;
    int d;
    step(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0);
      n_checks++;
      if ({locked, err_pulse, lock_lost, err_count} !== 19'd0) begin
        n_fail++; $display("FAIL zero_hunt %0d: got %b%b%b %0d want all zero", k, locked, err_pulse, lock_lost, err_count);
      end
    end
    g = 1;
    for (int k = 1; k <= LOCK; k++) begin
      next_word(d);
      step(0, 1, d);
      n_checks++;
      if (locked !== (k == LOCK)) begin
        n_fail++; $display("FAIL zero_then_1024 word %0d: got locked=%b want %b", k, locked, k == LOCK);
      end
    end
  endtask

  task automatic test_alternate;
    int d, nv;
    step(1, 0, 0);
    nv = 0;
    for (int c = 0; c < 2 * LOCK + 6; c++) begin
      if (c % 2 == 0) begin next_word(d); nv++; step(0, 1, d); end
      else step(0, 0, $urandom_range(0, 2047));
      n_checks++;
      if (locked !== (nv >= LOCK) || err_pulse !== 1'b0 || err_count !== 16'd0) begin
        n_fail++; $display("FAIL alternate cycle %0d: got locked=%b pulse=%b cnt=%0d want locked=%b", c, locked, err_pulse, err_count, nv >= LOCK);
      end
    end
  endtask

  task automatic test_reset_mid;
    int d;
    step(1, 0, 0);
    for (int k = 0; k < LOCK + 2; k++) begin next_word(d); step(0, 1, d); end
    for (int e = 0; e < 3; e++) begin
      next_word(d); step(0, 1, d ^ (1 << $urandom_range(0, 10)));
      next_word(d); step(0, 1, d);
    end
    n_checks++;
    if ({locked, err_count} !== {1'b1, 16'd3}) begin
      n_fail++; $display("FAIL pre_reset: got locked=%b cnt=%0d want 1 3", locked, err_count);
    end
    next_word(d);
    step(1, 1, d);
    n_checks++;
    if ({locked, err_pulse, lock_lost, err_count} !== 19'd0) begin
      n_fail++; $display("FAIL mid_reset: got %b%b%b %0d want all zero", locked, err_pulse, lock_lost, err_count);
    end
    for (int k = 1; k <= LOCK; k++) begin
      next_word(d);
      step(0, 1, d);
      n_checks++;
      if (locked !== (k == LOCK) || err_count !== 16'd0) begin
        n_fail++; $display("FAIL post_reset_relock %0d: got locked=%b cnt=%0d want %b 0", k, locked, err_count, k == LOCK);
      end
    end
  endtask

  task automatic test_random;
    int d;
    step(1, 0, 0);
    g = $urandom_range(0, PERIOD - 1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 80) begin
        next_word(d);
        if ($urandom_range(0, 99) < 6) d = d ^ $urandom_range(1, 2047);
        else if ($urandom_range(0, 99) < 2) d = 0;
        if ($urandom_range(0, 199) == 0) g += $urandom_range(1, 50);
        step(0, 1, d);
      end else step($urandom_range(0, 299) == 0, 0, $urandom_range(0, 2047));
      n_checks++;
      if ({locked, err_pulse, lock_lost, err_count} !== {m_locked, m_ep, m_ll, 16'(m_cnt)}) begin
        n_fail++; $display("FAIL random cycle %0d: got %b%b%b %0d want %b%b%b %0d", c, locked, err_pulse, lock_lost, err_count, m_locked, m_ep, m_ll, m_cnt);
      end
    end
  endtask

  initial begin
    int v, fb;
    v = 1;
    for (int i = 0; i < PERIOD; i++) begin
      seq[i] = v;
      pos[v] = i;
      fb = (v & 1) ^ ((v >> 2) & 1);
      v = (fb << 10) | (v >> 1);
    end
    m_state = 0; m_pidx = 0; m_run = 0; m_miss = 0; m_cnt = 0;
    m_locked = 0; m_ep = 0; m_ll = 0;
    #2;
    test_reset;
    test_lock_wrap;
    test_single_err;
    test_loss;
    test_zero_hunt;
    test_alternate;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr11_seq_checker.md
Name: lfsr11_seq_checker

Overview:
- Receive-side counterpart of the 11-bit LFSR pattern generator.
- Takes the generator's parallel 11-bit state word, one word per valid cycle, and synchronises a local predictor to it.
- Declares lock after a run of consecutive correct words, then counts bit-word errors while locked.
- Drops lock after sustained mismatch.
- Used in pattern-loopback tests, where it replaces file dumps of the generator output.

Parameters:
- WIDTH, 11: state word width; bit order [1:WIDTH], bit 1 is the MSB.
- TAP_A, 11: first feedback tap index.
- TAP_B, 9: second feedback tap index.
- LOCK_COUNT, 8: consecutive matches required to enter LOCKED, range 1..255.
- LOSS_COUNT, 4: consecutive mismatches in LOCKED that force re-hunt, range 1..255.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  [1:WIDTH]  received LFSR state word.
- locked  out  1  predictor is synchronised.
- err_pulse  out  1  one-cycle pulse: a valid word mismatched while LOCKED.
- err_count  out  ERR_W  saturating count of mismatched words while LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.

Behaviour:
- Next-state function, shared with the generator:
  - nxt(s) = {s[TAP_A]^s[TAP_B], s[1:WIDTH-1]}, i.e. the feedback bit enters at bit 1 and the word shifts toward bit WIDTH.
  - From seed 1 the sequence is 1, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 1026, ...
- Reset applies only on a clk edge with reset=1. Resulting values:
  - state = HUNT
  - pred = 0
  - run counters = 0
  - locked = 0, err_pulse = 0, lock_lost = 0
  - err_count = 0
- Cycles with in_valid=0 hold all state and counters; pulses are 0 on those cycles.
- FSM, evaluated only on valid cycles; "match" means in_data == pred:
  - HUNT:
    - in_data == 0 is ignored (illegal LFSR state); stay in HUNT.
    - Otherwise: pred <= nxt(in_data), match_run <= 1, go to VERIFY. If LOCK_COUNT == 1, go directly to LOCKED.
  - VERIFY:
    - Match: pred <= nxt(pred), match_run++. When match_run reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: reseed from this word exactly as HUNT does (pred <= nxt(in_data), match_run <= 1), stay in VERIFY. If in_data == 0, go to HUNT instead.
  - LOCKED:
    - pred always advances as pred <= nxt(pred) (flywheel); the received word never reseeds it.
    - Match: miss_run <= 0.
    - Mismatch, including in_data == 0:
      - err_pulse = 1 next cycle.
      - err_count++, saturating at all-ones.
      - miss_run++.
      - When miss_run reaches LOSS_COUNT: go to HUNT, lock_lost = 1 next cycle, miss_run <= 0.
- Output timing:
  - locked is a registered decode of state == LOCKED. It rises on the clk edge that consumes the LOCK_COUNT-th consecutive match, counting the seeding word as match 1.
  - err_pulse and lock_lost are registered, one cycle wide.
- err_count persists across lock loss. It clears only on reset.
- Reset asserted mid-stream overrides everything on that edge, whatever the state or in_valid.
- Run counters are 8 bits wide.
- ERR_W saturation: the count holds at 2^ERR_W-1; further errors still pulse err_pulse.

Decomposition:
- Package lfsr11_pkg holds:
  - state enum {HUNT, VERIFY, LOCKED}
  - the WIDTH, TAP_A and TAP_B defaults
  - function lfsr_next(). The generator also imports this function so both sides share one definition.
- One sub-module is natural: sat_counter (parameterised width, synchronous clear, increment enable, saturate), instantiated for err_count.

Test Plan:
1. Reset, then a clean generator stream seeded 1 with in_valid=1 every cycle, LOCK_COUNT=8 -> locked=1 after the 8th word (value 16 accepted). err_count stays 0 over 2047 words. Sequence wraps back to 1 after 2047 words with no error.
2. Locked stream, then in_data[6] flipped on one word -> err_pulse exactly once, err_count=1, locked stays 1. The next correct word matches (flywheel, no reseed).
3. Locked stream, then 4 consecutive corrupted words (LOSS_COUNT=4) -> lock_lost pulse, locked=0, err_count=4. The clean stream re-locks after 8 more words and err_count remains 4.
4. All-zero words in HUNT for 20 cycles -> no state change, locked=0. Then a valid stream starting at 1024 -> locks after 8 words.
5. in_valid toggled 1/0 on alternate cycles with the clean stream -> lock after 8 valid words (16 cycles). Idle cycles produce no errors.
6. reset pulsed for one cycle while LOCKED with err_count=3 -> next cycle locked=0, err_count=0, state HUNT. Re-locks normally afterwards.
